// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
//   rsp_err_e  : response status code carried with every fetch response
//   NOP_INSTR  : instruction returned whenever a fetch cannot be served
//   rsp_t      : one response record (instr, addr, err), used by the read
//                pipeline and by the response FIFO
//   addr_err   : classifies a fetch address from its alignment/range bits
package imem_pkg;

    typedef enum logic [1:0] {
        ERR_OK         = 2'd0,
        ERR_MISALIGNED = 2'd1,
        ERR_RANGE      = 2'd2,
        ERR_PARITY     = 2'd3
    } rsp_err_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] addr;
        rsp_err_e    err;
    } rsp_t;

    // Misalignment outranks the range check.
    function automatic rsp_err_e addr_err(input logic [1:0] byte_off, input logic above_top);
        if (byte_off != 2'b00) begin
            return ERR_MISALIGNED;
        end else if (above_top) begin
            return ERR_RANGE;
        end
        return ERR_OK;
    endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Show-ahead response FIFO: the head entry is visible on dout whenever
// empty is low, and pop removes it at the clock edge.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   clr             : synchronous clear (drops every entry), wins over push
//   push, din       : write an entry (accepted when not full, or when full
//                     and popping in the same cycle)
//   pop             : remove the head entry (ignored when empty)
//   dout            : head entry
//   full, empty     : occupancy flags
//   count           : number of stored entries
module rsp_fifo #(
    parameter int WIDTH = 98,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign count  = count_q;
    assign dout   = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    // A full FIFO can still take a new entry if the head leaves this cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch interface.
// Accepts byte-addressed fetch requests, reads a word-addressed store through
// a fixed-latency pipeline and returns responses in order through a
// show-ahead FIFO so the consumer can back-pressure fetch.
// Optional feature macro: IMEM_PARITY_EN adds an even-parity bit per stored
// word and reports ERR_PARITY on a read mismatch.
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   flush                      : drop every in-flight and queued response
//   req_valid/req_ready/req_addr : fetch request handshake, byte address
//   rsp_valid/rsp_ready        : response handshake
//   rsp_instr/rsp_addr/rsp_err : instruction word, echoed address, status
//   ld_we/ld_addr/ld_wdata     : program-load write port (word index)
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [63:0]              req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_instr,
    output logic [63:0]              rsp_addr,
    output logic [1:0]               rsp_err,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_wdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(FIFO_DEPTH + LATENCY) + 1;
    localparam int RW = $bits(rsp_t);

`ifdef IMEM_PARITY_EN
    localparam int MW = 33;
`else
    localparam int MW = 32;
`endif

    // ------------------------------------------------------------------
    // Request decode and accept
    // ------------------------------------------------------------------
    logic           accept;
    logic [AW-1:0]  req_idx;
    rsp_err_e       req_err;
    logic           rd_en;

    assign req_idx = req_addr[2 +: AW];
    // DEPTH is a power of two, so any set bit above the index field means
    // the address lies at or beyond 4*DEPTH.
    assign req_err = addr_err(req_addr[1:0], |req_addr[63:AW+2]);
    assign accept  = req_valid && req_ready;
    assign rd_en   = accept && (req_err == ERR_OK);

    // ------------------------------------------------------------------
    // Word storage: registered read, read-before-write on collisions
    // ------------------------------------------------------------------
    logic [MW-1:0] mem_q [DEPTH];
    logic [MW-1:0] rd_data_q;
    logic [MW-1:0] ld_word;
    logic          par_bad;

`ifdef IMEM_PARITY_EN
    assign ld_word = {^ld_wdata, ld_wdata};
    assign par_bad = ^rd_data_q;
`else
    assign ld_word = ld_wdata;
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem_q[req_idx];
        end
        if (ld_we) begin
            mem_q[ld_addr] <= ld_word;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. Stage 0 holds the request metadata alongside the RAM
    // output register; later stages just delay the finished record.
    // ------------------------------------------------------------------
    logic        s1_valid_q, s1_valid_d;
    logic [63:0] s1_addr_q;
    rsp_err_e    s1_err_q;
    rsp_t        s1_rsp;

    logic        pv [LATENCY];
    rsp_t        pr [LATENCY];

    assign s1_valid_d = accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_err_q   <= ERR_OK;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_addr_q <= req_addr;
                s1_err_q  <= req_err;
            end
        end
    end

    // Address errors outrank parity; any error returns a NOP.
    always_comb begin
        s1_rsp.addr  = s1_addr_q;
        s1_rsp.err   = s1_err_q;
        s1_rsp.instr = NOP_INSTR;
        if (s1_err_q == ERR_OK) begin
            if (par_bad) begin
                s1_rsp.err = ERR_PARITY;
            end else begin
                s1_rsp.instr = rd_data_q[31:0];
            end
        end
    end

    assign pv[0] = s1_valid_q;
    assign pr[0] = s1_rsp;

    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
        logic valid_q;
        rsp_t rsp_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                rsp_q   <= '0;
            end else begin
                valid_q <= pv[gi-1] && !flush;
                if (pv[gi-1]) begin
                    rsp_q <= pr[gi-1];
                end
            end
        end

        assign pv[gi] = valid_q;
        assign pr[gi] = rsp_q;
    end

    // ------------------------------------------------------------------
    // Response FIFO with a bypass: when the FIFO is empty the last pipe
    // stage drives the outputs directly, and is only pushed if it is not
    // taken this cycle. Once pushed it reappears unchanged as the FIFO head,
    // so the outputs stay stable while rsp_ready is low.
    // ------------------------------------------------------------------
    logic                      last_valid;
    rsp_t                      last_rsp;
    logic                      fifo_push, fifo_pop;
    logic [RW-1:0]             fifo_dout;
    logic                      fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    rsp_t                      out_rsp;
    logic                      out_valid;

    assign last_valid = pv[LATENCY-1];
    assign last_rsp   = pr[LATENCY-1];
    assign fifo_push  = last_valid && !(fifo_empty && rsp_ready);
    assign fifo_pop   = rsp_ready && !fifo_empty;

    rsp_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (fifo_push),
        .din   (last_rsp),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        out_valid = 1'b0;
        out_rsp   = '0;
        if (!fifo_empty) begin
            out_valid = 1'b1;
            out_rsp   = rsp_t'(fifo_dout);
        end else if (last_valid) begin
            out_valid = 1'b1;
            out_rsp   = last_rsp;
        end
    end

    assign rsp_valid = out_valid;
    assign rsp_instr = out_rsp.instr;
    assign rsp_addr  = out_rsp.addr;
    assign rsp_err   = out_rsp.err;

    // ------------------------------------------------------------------
    // Credit: every accepted request owns a FIFO slot until it is popped.
    // A pop in the current cycle is deliberately not credited so that
    // req_ready never depends combinationally on rsp_ready.
    // ------------------------------------------------------------------
    logic [OW-1:0] outstanding;

    always_comb begin
        outstanding = OW'(fifo_count);
        for (int i = 0; i < LATENCY; i++) begin
            outstanding = outstanding + OW'(pv[i]);
        end
    end

    assign req_ready = !rst && !flush && !fifo_full && (outstanding < OW'(FIFO_DEPTH));

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

    localparam int DEPTH      = 1024;
    localparam int LATENCY    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, req_ready, rsp_valid, rsp_ready, ld_we;
    logic [63:0] req_addr, rsp_addr;
    logic [31:0] rsp_instr, ld_wdata;
    logic [1:0]  rsp_err;
    logic [9:0]  ld_addr;

    imem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr), .rsp_addr(rsp_addr), .rsp_err(rsp_err),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [63:0] addr;
        logic [1:0]  err;
        int          cyc;
    } exp_t;

    logic [31:0] model_mem [DEPTH];
    bit          corrupt   [DEPTH];
    exp_t        sb[$];
    int          cyc = 0;

    function automatic logic [31:0] pat(input int i);
        return 32'h1357_0000 ^ (32'(i) * 32'h0000_9E37);
    endfunction

    function automatic void expect_for(input logic [63:0] a, output logic [31:0] ins, output logic [1:0] er);
        int unsigned w;
        ins = NOP;
        if (a % 4 != 0)                     er = 2'd1;
        else if (a >= 64'(4 * DEPTH))       er = 2'd2;
        else begin
            w = 32'(a / 4);
            if (corrupt[w]) er = 2'd3;
            else begin er = 2'd0; ins = model_mem[w]; end
        end
    endfunction

    // Cycle-level monitor: checks credit, response timing and contents.
    always @(negedge clk) begin
        bit          exp_ready, exp_valid;
        exp_t        e;
        if (rst) begin
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_rsp_instr", 64'(rsp_instr), 64'd0);
            chk("rst_rsp_addr",  rsp_addr,       64'd0);
            chk("rst_rsp_err",   64'(rsp_err),   64'd0);
            sb.delete();
        end else begin
            exp_ready = !flush && (sb.size() < FIFO_DEPTH);
            exp_valid = (sb.size() > 0) && (cyc >= sb[0].cyc + LATENCY);
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
            if (exp_valid && rsp_valid) begin
                chk("rsp_instr", 64'(rsp_instr), 64'(sb[0].instr));
                chk("rsp_addr",  rsp_addr,       sb[0].addr);
                chk("rsp_err",   64'(rsp_err),   64'(sb[0].err));
            end
            if (exp_valid && rsp_ready) void'(sb.pop_front());
            if (req_valid && exp_ready) begin
                expect_for(req_addr, e.instr, e.err);
                e.addr = req_addr;
                e.cyc  = cyc;
                sb.push_back(e);
            end
            if (flush) sb.delete();
            if (ld_we) begin
                model_mem[ld_addr] = ld_wdata;
                corrupt[ld_addr]   = 1'b0;
            end
        end
        cyc++;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_req(input logic [63:0] a, output logic [31:0] ins, output logic [63:0] ra,
                          output logic [1:0] er, output int lat, output bit ok);
        bit got;
        req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
        got = 0; lat = 0; ins = '0; ra = '0; er = '0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready) begin got = 1; break; end
        end
        tick();
        req_valid = 1'b0;
        ok = 0;
        if (got) begin
            for (int n = 1; n <= 50; n++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    ins = rsp_instr; ra = rsp_addr; er = rsp_err; lat = n; ok = 1;
                    break;
                end
            end
            tick();
        end
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [1:0]  err;
        logic [31:0] instr;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] g_ins;
    logic [63:0] g_addr;
    logic [1:0]  g_err;
    int          g_lat, acc, nrsp;
    bit          g_ok, rdy;
    logic [63:0] seen[$];

    initial begin
        rst = 1'b1; flush = 0; req_valid = 0; req_addr = '0; rsp_ready = 0;
        ld_we = 0; ld_addr = '0; ld_wdata = '0;
        for (int i = 0; i < DEPTH; i++) corrupt[i] = 1'b0;
        repeat (3) @(negedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("req_ready_after_rst", 64'(req_ready), 64'd1);

        // preload
        for (int i = 0; i < DEPTH; i++) begin
            ld_we = 1; ld_addr = 10'(i); ld_wdata = (i == 1) ? 32'h00A0_0093 : pat(i);
            tick();
        end
        ld_we = 0;
        tick();

        // table-driven single requests
        vecs[0] = '{64'h4,                   2'd0, 32'h00A0_0093};
        vecs[1] = '{64'h6,                   2'd1, NOP};
        vecs[2] = '{64'h1000,                2'd2, NOP};
        vecs[3] = '{64'hFFC,                 2'd0, pat(1023)};
        vecs[4] = '{64'h0,                   2'd0, pat(0)};
        vecs[5] = '{64'h1,                   2'd1, NOP};
        vecs[6] = '{64'h1003,                2'd1, NOP};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFF0, 2'd2, NOP};
        vecs[8] = '{64'h8,                   2'd0, pat(2)};
        vecs[9] = '{64'h1_0000_0000,         2'd2, NOP};
        for (int v = 0; v < 10; v++) begin
            do_req(vecs[v].addr, g_ins, g_addr, g_err, g_lat, g_ok);
            chk("vec_done",    64'(g_ok),  64'd1);
            chk("vec_latency", 64'(g_lat), 64'(LATENCY));
            chk("vec_instr",   64'(g_ins), 64'(vecs[v].instr));
            chk("vec_addr",    g_addr,     vecs[v].addr);
            chk("vec_err",     64'(g_err), 64'(vecs[v].err));
            $display("vec %0d addr=%h instr=%h err=%0d lat=%0d", v, g_addr, g_ins, g_err, g_lat);
        end

        // full back-pressure
        rsp_ready = 0; req_valid = 1; req_addr = 64'h0; acc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); rdy = req_ready;
            tick();
            if (rdy) begin acc++; req_addr = req_addr + 64'd4; end
        end
        req_valid = 0;
        chk("bp_accepted", 64'(acc), 64'(FIFO_DEPTH));
        @(negedge clk);
        chk("bp_ready_low", 64'(req_ready), 64'd0);
        tick();
        rsp_ready = 1; seen.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) seen.push_back(rsp_addr);
        end
        chk("bp_rsp_count", 64'(seen.size()), 64'(FIFO_DEPTH));
        for (int i = 0; i < seen.size() && i < FIFO_DEPTH; i++) chk("bp_rsp_order", seen[i], 64'(4 * i));
        $display("backpressure accepted=%0d responses=%0d", acc, seen.size());
        tick();

        // flush with two in the pipe and one queued
        rsp_ready = 0; req_valid = 1; req_addr = 64'h20;
        tick(); req_addr = 64'h24;
        tick(); req_addr = 64'h28;
        tick(); req_valid = 0; flush = 1;
        @(negedge clk);
        chk("flush_ready_low", 64'(req_ready), 64'd0);
        tick(); flush = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("flush_no_rsp", 64'(rsp_valid), 64'd0);
        end
        tick();
        do_req(64'h10, g_ins, g_addr, g_err, g_lat, g_ok);
        chk("post_flush_done",  64'(g_ok),  64'd1);
        chk("post_flush_addr",  g_addr,     64'h10);
        chk("post_flush_instr", 64'(g_ins), 64'(pat(4)));
        $display("flush then req addr=%h instr=%h", g_addr, g_ins);

        // load/read collision
        rsp_ready = 1; req_valid = 1; req_addr = 64'h14;
        ld_we = 1; ld_addr = 10'd5; ld_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("coll_ready", 64'(req_ready), 64'd1);
        tick(); req_valid = 0; ld_we = 0; nrsp = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid && nrsp == 0) begin
                chk("coll_old_data", 64'(rsp_instr), 64'(pat(5)));
                nrsp++;
            end
        end
        chk("coll_rsp_seen", 64'(nrsp), 64'd1);
        tick();
        do_req(64'h14, g_ins, g_addr, g_err, g_lat, g_ok);
        chk("coll_new_data", 64'(g_ins), 64'hDEAD_BEEF);
        $display("collision reread instr=%h", g_ins);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            tick();
            req_valid = ($urandom_range(0, 99) < 60);
            r = $urandom_range(0, 9);
            if (r < 7)       req_addr = 64'($urandom_range(0, DEPTH - 1)) * 64'd4;
            else if (r == 7) req_addr = 64'($urandom_range(0, DEPTH - 1)) * 64'd4 + 64'($urandom_range(1, 3));
            else if (r == 8) req_addr = {32'($urandom), 32'($urandom)} | 64'h1000 & ~64'h3;
            else             req_addr = ($urandom_range(0, 1) == 1) ? 64'hFFC : 64'h1000;
            rsp_ready = ($urandom_range(0, 99) < 55);
            flush     = ($urandom_range(0, 99) < 3);
            ld_we     = ($urandom_range(0, 99) < 8);
            ld_addr   = 10'($urandom_range(0, DEPTH - 1));
            ld_wdata  = $urandom;
        end
        tick();
        req_valid = 0; flush = 0; ld_we = 0; rsp_ready = 1;
        repeat (20) tick();
        $display("random phase done, checks so far=%0d", n_checks);

        // reset mid-stream with a full FIFO
        rsp_ready = 0; req_valid = 1; req_addr = 64'h40;
        repeat (8) tick();
        req_valid = 0;
        @(negedge clk);
        chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
        tick();
        rst = 1; #1;
        chk("rst_immediate_valid", 64'(rsp_valid), 64'd0);
        chk("rst_immediate_ready", 64'(req_ready), 64'd0);
        repeat (2) tick();
        rst = 0; rsp_ready = 1;
        @(negedge clk);
        chk("rst_release_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_stale", 64'(rsp_valid), 64'd0);
        end
        $display("mid-stream reset recovered");
        tick();

`ifdef IMEM_PARITY_EN
        dut.mem_q[9] = dut.mem_q[9] ^ {1'b1, 32'h0};
        corrupt[9] = 1'b1;
        do_req(64'h24, g_ins, g_addr, g_err, g_lat, g_ok);
        chk("parity_err",   64'(g_err), 64'd3);
        chk("parity_instr", 64'(g_ins), 64'(NOP));
        $display("parity flip err=%0d instr=%h", g_err, g_ins);
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
